// File: rtl/aes_cipher_iter_if.sv
// Handshake bundle for the iterative AES cipher core.
// Ports carried:
//   in_valid / in_ready    - input block handshake (source -> core)
//   plain_text, round_keys - input block and the full expanded key schedule
//   out_valid / out_ready  - output block handshake (core -> consumer)
//   cipher_text            - encrypted block
//   busy, round_idx        - status/debug from the core
// The master modport is the side that supplies blocks and consumes results;
// the slave modport is the core itself.
interface aes_cipher_iter_if #(
  parameter int NK = 4
);
  localparam int NR = NK + 6;

  logic                      in_valid;
  logic                      in_ready;
  logic [0:127]              plain_text;
  logic [0:128*(NR+1)-1]     round_keys;
  logic                      out_valid;
  logic                      out_ready;
  logic [0:127]              cipher_text;
  logic                      busy;
  logic [3:0]                round_idx;

  modport master (
    output in_valid, plain_text, round_keys, out_ready,
    input  in_ready, out_valid, cipher_text, busy, round_idx
  );

  modport slave (
    input  in_valid, plain_text, round_keys, out_ready,
    output in_ready, out_valid, cipher_text, busy, round_idx
  );
endinterface

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core, one round per clock, AES-128/192/256 by NK.
// Ports:
//   clk    - clock
//   reset  - asynchronous, active-high reset
//   bus    - aes_cipher_iter_if.slave: valid/ready input of plain_text plus
//            all round keys (key i at [128*i +: 128]), valid/ready output of
//            cipher_text, and busy / round_idx status.
// A block is accepted in IDLE, or in DONE on the same edge the previous result
// is retired, so back-to-back blocks cost NR+1 cycles each. The key schedule
// is latched on accept; the inputs are free to change afterwards.
module aes_cipher_iter #(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             reset,
  aes_cipher_iter_if.slave bus
);
  localparam int NR = NK + 6;
  localparam logic [3:0] LAST_ROUND = 4'(NR - 1);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_cipher_iter: NK must be 4, 6 or 8, got %0d", NK);
  end

  // Forward S-box, entry b at [8*b +: 8].
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  // NOTE: functions are pure combinational helpers; their local variables use
  // blocking assignment because each value is consumed within the same call.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:127] sub_bytes(input logic [0:127] s);
    logic [0:127] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[{s[8*i +: 8], 3'b000} +: 8];
    return r;
  endfunction

  // Byte (row r, column c) lives at index r + 4*c; row r rotates left by r.
  function automatic logic [0:127] shift_rows(input logic [0:127] s);
    logic [0:127] r;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        r[8*(row + 4*col) +: 8] = s[8*(row + 4*((col + row) % 4)) +: 8];
    return r;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      r[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  state_t       state;
  logic [3:0]   round_idx;
  logic [0:127] state_reg;
  logic [0:127] cipher_reg;
  logic [0:127] key_mem [NR+1];
  logic [0:127] round_block;
  logic [0:127] final_block;
  logic         in_ready;
  logic         accept;

  // DONE only makes room for a new block on the edge the result is retired.
  assign in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign round_block = mix_columns(shift_rows(sub_bytes(state_reg))) ^ key_mem[round_idx];
  assign final_block = shift_rows(sub_bytes(state_reg)) ^ key_mem[NR];

  // NOTE: the key schedule is plain storage with no reset; it is always
  // rewritten on accept before any round reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i <= NR; i++) key_mem[i] <= bus.round_keys[128*i +: 128];
    end
  end

  // NOTE: all state registers use non-blocking assignment so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      round_idx  <= 4'd0;
      state_reg  <= '0;
      cipher_reg <= '0;
    end else begin
      case (state)
        ROUND: begin
          state_reg <= round_block;
          round_idx <= round_idx + 4'd1;
          if (round_idx == LAST_ROUND) state <= FINAL;
        end
        FINAL: begin
          state_reg  <= final_block;
          cipher_reg <= final_block;
          state      <= DONE;
        end
        default: begin
          // IDLE and DONE: accept covers both fresh starts and zero-bubble restarts.
          if (accept) begin
            state_reg <= bus.plain_text ^ bus.round_keys[0 +: 128];
            round_idx <= 4'd1;
            state     <= ROUND;
          end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state == DONE);
  assign bus.busy        = (state == ROUND) || (state == FINAL);
  assign bus.round_idx   = round_idx;
  assign bus.cipher_text = cipher_reg;
endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed testbench for aes_cipher_iter: FIPS-197 vectors for AES-128/192/256,
// latency, back-pressure, zero-bubble restart, input scrambling while busy and
// reset mid-block. Round keys are expanded here from the cipher keys using an
// S-box derived from the GF(2^8) inverse and affine map.
module tb_aes_cipher_iter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0]    sb [256];
  logic [0:1919] rk;
  int            lat;
  bit            seen;

  always #5 clk = ~clk;

  aes_cipher_iter_if #(.NK(4)) if4 ();
  aes_cipher_iter_if #(.NK(6)) if6 ();
  aes_cipher_iter_if #(.NK(8)) if8 ();

  aes_cipher_iter #(.NK(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  aes_cipher_iter #(.NK(6)) dut6 (.clk(clk), .reset(reset), .bus(if6));
  aes_cipher_iter #(.NK(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Key is left-aligned in 256 bits; returns round keys, key i at [128*i +: 128].
  function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [0:1919] r = '0;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        w[i] = key[32*i +: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      r[32*i +: 32] = w[i];
    end
    return r;
  endfunction

  function automatic logic get_out_valid(input int which);
    case (which)
      6:       return if6.out_valid;
      8:       return if8.out_valid;
      default: return if4.out_valid;
    endcase
  endfunction

  // Called right after in_valid is raised at a negedge. Returns the number of
  // edges between the accept edge and the edge where out_valid rose (-1 on
  // timeout). Leaves out_ready low so the result is held in DONE.
  task automatic wait_out(input int which, input bit hold_valid, input bit scramble,
                          output int latency);
    int  n = 0;
    bit  got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if4.out_ready = 1'b0;
        if6.out_ready = 1'b0;
        if8.out_ready = 1'b0;
        if (!hold_valid) begin
          if4.in_valid = 1'b0;
          if6.in_valid = 1'b0;
          if8.in_valid = 1'b0;
        end
      end
      if (scramble) begin
        for (int i = 0; i < 4; i++) if4.plain_text[32*i +: 32] = $urandom();
        for (int i = 0; i < 44; i++) if4.round_keys[32*i +: 32] = $urandom();
      end
      got = get_out_valid(which);
    end
    latency = got ? n - 1 : -1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      sb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end

    if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.plain_text = '0; if4.round_keys = '0;
    if6.in_valid = 1'b0; if6.out_ready = 1'b0; if6.plain_text = '0; if6.round_keys = '0;
    if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.plain_text = '0; if8.round_keys = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_in_ready",  128'(if4.in_ready),  128'(1));
    check("reset_out_valid", 128'(if4.out_valid), 128'(0));
    check("reset_busy",      128'(if4.busy),      128'(0));
    check("reset_round_idx", 128'(if4.round_idx), 128'(0));
    check("reset_ct",        if4.cipher_text,     128'h0);

    // AES-128 App.B, result held under back-pressure.
    @(negedge clk);
    rk = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    if4.plain_text = 128'h3243f6a8885a308d313198a2e0370734;
    if4.round_keys = rk[0 +: 1408];
    if4.in_valid   = 1'b1;
    wait_out(4, 1'b0, 1'b0, lat);
    check("aes128_latency", 128'(lat), 128'(10));
    check("aes128_ct", if4.cipher_text, 128'h3925841d02dc09fbdc118597196a0b32);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_ct_stable", if4.cipher_text, 128'h3925841d02dc09fbdc118597196a0b32);
      check("bp_out_valid", 128'(if4.out_valid), 128'(1));
      check("bp_in_ready",  128'(if4.in_ready),  128'(0));
    end

    // Retire and accept the next block on the same edge (App.C.1), then
    // scramble inputs every cycle with in_valid held high while busy.
    @(negedge clk);
    rk = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    if4.plain_text = 128'h00112233445566778899aabbccddeeff;
    if4.round_keys = rk[0 +: 1408];
    if4.in_valid   = 1'b1;
    if4.out_ready  = 1'b1;
    #1;
    check("b2b_in_ready", 128'(if4.in_ready), 128'(1));
    wait_out(4, 1'b1, 1'b1, lat);
    if4.in_valid = 1'b0;
    check("b2b_latency", 128'(lat), 128'(10));
    check("b2b_ct", if4.cipher_text, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    if4.out_ready = 1'b1;
    @(negedge clk);
    check("retire_out_valid", 128'(if4.out_valid), 128'(0));
    check("retire_in_ready",  128'(if4.in_ready),  128'(1));
    if4.out_ready = 1'b0;

    // Reset at round 5 discards the block.
    rk = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    if4.plain_text = 128'h3243f6a8885a308d313198a2e0370734;
    if4.round_keys = rk[0 +: 1408];
    if4.in_valid   = 1'b1;
    @(negedge clk);
    if4.in_valid = 1'b0;
    check("run_round_idx1", 128'(if4.round_idx), 128'(1));
    check("run_busy",       128'(if4.busy),      128'(1));
    check("run_in_ready",   128'(if4.in_ready),  128'(0));
    repeat (4) @(negedge clk);
    check("run_round_idx5", 128'(if4.round_idx), 128'(5));
    reset = 1'b1;
    #1;
    check("mid_reset_out_valid", 128'(if4.out_valid), 128'(0));
    check("mid_reset_busy",      128'(if4.busy),      128'(0));
    check("mid_reset_round_idx", 128'(if4.round_idx), 128'(0));
    check("mid_reset_ct",        if4.cipher_text,     128'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", 128'(if4.in_ready), 128'(1));
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (if4.out_valid) seen = 1'b1;
    end
    check("no_partial_output", 128'(seen), 128'(0));

    // Fresh App.B block after the reset.
    if4.in_valid = 1'b1;
    wait_out(4, 1'b0, 1'b0, lat);
    check("fresh_latency", 128'(lat), 128'(10));
    check("fresh_ct", if4.cipher_text, 128'h3925841d02dc09fbdc118597196a0b32);
    if4.out_ready = 1'b1;
    @(negedge clk);
    if4.out_ready = 1'b0;

    // AES-192, App.C.2.
    rk = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    if6.plain_text = 128'h00112233445566778899aabbccddeeff;
    if6.round_keys = rk[0 +: 1664];
    if6.in_valid   = 1'b1;
    wait_out(6, 1'b0, 1'b0, lat);
    check("aes192_latency", 128'(lat), 128'(12));
    check("aes192_ct", if6.cipher_text, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);

    // AES-256, App.C.3.
    @(negedge clk);
    rk = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    if8.plain_text = 128'h00112233445566778899aabbccddeeff;
    if8.round_keys = rk;
    if8.in_valid   = 1'b1;
    wait_out(8, 1'b0, 1'b0, lat);
    check("aes256_latency", 128'(lat), 128'(14));
    check("aes256_ct", if8.cipher_text, 128'h8ea2b7ca516745bfeafc49904b496089);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
